// File: rtl/cpu_debug_ctrl.sv
// Bring-up/debug controller: core reset sequencing, run/halt/step gating,
// write breakpoint and a small watched data memory.
module cpu_debug_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 8,
  parameter int LED_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic              CLK100MHZ,
  input  logic              RESET,
  input  logic              RUN_EN,
  input  logic              STEP_REQ,
  input  logic              BRK_EN,
  input  logic [31:0]       BRK_ADDR,
  input  logic [31:0]       WATCH_ADDR,
  output logic              CPU_RST_N,
  output logic              CPU_CK_EN,
  input  logic [31:0]       DMEM_ADDR,
  input  logic              DMEM_READ_WRN,
  input  logic [DATA_W-1:0] DMEM_WDATA,
  output logic [DATA_W-1:0] DMEM_RDATA,
  output logic [LED_W-1:0]  LED,
  output logic [CNT_W-1:0]  WR_COUNT,
  output logic              BRK_HIT,
  output logic [1:0]        STATE
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HC_W = $clog2(RST_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic              step_prev_q, step_prev_d;
  logic              brk_hit_q, brk_hit_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic ck_en;
  logic wr_req;
  logic wr_in_range;
  logic wr_commit;
  logic brk_now;
  logic step_edge;
  logic brk_clear;
  logic rd_in_range;
  logic watch_in_range;
  logic [DATA_W-1:0] watch_word;

  assign ck_en       = (state_q == S_RUN) || (state_q == S_STEP);
  assign wr_req      = ~DMEM_READ_WRN & ck_en;
  assign wr_in_range = DMEM_ADDR < 32'(DEPTH);
  assign wr_commit   = wr_req & wr_in_range;
  assign brk_now     = BRK_EN & wr_req & (DMEM_ADDR == BRK_ADDR);
  assign step_edge   = STEP_REQ & ~step_prev_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    step_prev_d = STEP_REQ;
    brk_clear   = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HC_W'(RST_CYCLES - 1)) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (RUN_EN && !brk_hit_q) begin
          state_d = S_RUN;
        end else if (step_edge) begin
          state_d   = S_STEP;
          brk_clear = 1'b1;
        end
      end
      S_RUN: begin
        if (brk_now || !RUN_EN) begin
          state_d = S_HALT;
        end
      end
      S_STEP: begin
        state_d = S_HALT;
      end
      default: state_d = S_HOLD;
    endcase
    if (!RUN_EN && state_q != S_RUN) begin
      brk_clear = 1'b1;
    end
  end

  // A hit in the same cycle as a clear keeps the flag set.
  always_comb begin
    brk_hit_d = brk_hit_q;
    if (brk_now) begin
      brk_hit_d = 1'b1;
    end else if (brk_clear) begin
      brk_hit_d = 1'b0;
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_commit) begin
      mem_d[DMEM_ADDR[AW-1:0]] = DMEM_WDATA;
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_HOLD;
      hold_q      <= '0;
      step_prev_q <= 1'b1;
      brk_hit_q   <= 1'b0;
      wr_cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      step_prev_q <= step_prev_d;
      brk_hit_q   <= brk_hit_d;
      wr_cnt_q    <= wr_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_in_range    = DMEM_ADDR < 32'(DEPTH);
  assign watch_in_range = WATCH_ADDR < 32'(DEPTH);
  assign watch_word     = watch_in_range ? mem_q[WATCH_ADDR[AW-1:0]]
                                         : '0;

  assign DMEM_RDATA = rd_in_range ? mem_q[DMEM_ADDR[AW-1:0]] : '0;
  assign LED        = watch_word[LED_W-1:0];
  assign WR_COUNT   = wr_cnt_q;
  assign BRK_HIT    = brk_hit_q;
  assign STATE      = state_q;
  assign CPU_CK_EN  = ck_en;
  assign CPU_RST_N  = (state_q != S_HOLD);

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl: reset hold, run, breakpoint,
// single-step, out-of-range writes and mid-run reset.
module tb_cpu_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_en, step_req, brk_en;
  logic [31:0] brk_addr, watch_addr, dmem_addr;
  logic        dmem_read_wrn;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        cpu_rst_n, cpu_ck_en, brk_hit;
  logic [3:0]  led;
  logic [15:0] wr_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int ck_cnt;

  always #5 clk = ~clk;

  cpu_debug_ctrl dut (
    .CLK100MHZ    (clk),
    .RESET        (rst),
    .RUN_EN       (run_en),
    .STEP_REQ     (step_req),
    .BRK_EN       (brk_en),
    .BRK_ADDR     (brk_addr),
    .WATCH_ADDR   (watch_addr),
    .CPU_RST_N    (cpu_rst_n),
    .CPU_CK_EN    (cpu_ck_en),
    .DMEM_ADDR    (dmem_addr),
    .DMEM_READ_WRN(dmem_read_wrn),
    .DMEM_WDATA   (dmem_wdata),
    .DMEM_RDATA   (dmem_rdata),
    .LED          (led),
    .WR_COUNT     (wr_count),
    .BRK_HIT      (brk_hit),
    .STATE        (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    run_en = 0; step_req = 0; brk_en = 0;
    brk_addr = 0; watch_addr = 0; dmem_addr = 0;
    dmem_read_wrn = 1; dmem_wdata = 0;
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_rstn", 32'(cpu_rst_n), 0);
    chk("rst_cken", 32'(cpu_ck_en), 0);
    chk("rst_cnt", 32'(wr_count), 0);
    chk("rst_brk", 32'(brk_hit), 0);

    // release, with a write request pending that must be ignored
    rst = 0;
    dmem_addr = 3; dmem_read_wrn = 0; dmem_wdata = 32'hdead;
    repeat (7) tick();
    chk("hold7_rstn", 32'(cpu_rst_n), 0);
    chk("hold7_state", 32'(state), 0);
    tick();
    chk("hold8_rstn", 32'(cpu_rst_n), 1);
    chk("hold8_state", 32'(state), 1);
    chk("halt_cken", 32'(cpu_ck_en), 0);
    tick(); tick();
    chk("halt_wr_cnt", 32'(wr_count), 0);
    dmem_read_wrn = 1; #1;
    chk("halt_wr_mem", dmem_rdata, 0);

    // run and two writes to addr 1
    run_en = 1;
    tick();
    chk("run_state", 32'(state), 2);
    chk("run_cken", 32'(cpu_ck_en), 1);
    dmem_addr = 1; dmem_wdata = 32'h5; dmem_read_wrn = 0;
    tick();
    dmem_wdata = 32'hA; #1;
    chk("rd_old_data", dmem_rdata, 32'h5);
    tick();
    dmem_read_wrn = 1; watch_addr = 1; #1;
    chk("led_A", 32'(led), 32'hA);
    chk("cnt_2", 32'(wr_count), 2);
    chk("rd_new_data", dmem_rdata, 32'hA);

    // breakpoint on addr 2
    brk_en = 1; brk_addr = 2;
    dmem_addr = 2; dmem_wdata = 32'h77; dmem_read_wrn = 0;
    tick();
    dmem_read_wrn = 1; #1;
    chk("brk_hit", 32'(brk_hit), 1);
    chk("brk_state", 32'(state), 1);
    chk("brk_cken", 32'(cpu_ck_en), 0);
    chk("brk_mem", dmem_rdata, 32'h77);
    chk("brk_cnt", 32'(wr_count), 3);
    tick(); tick();
    chk("brk_stay_halt", 32'(state), 1);
    chk("brk_stay_flag", 32'(brk_hit), 1);
    run_en = 0;
    tick();
    chk("brk_cleared", 32'(brk_hit), 0);
    chk("brk_clr_state", 32'(state), 1);
    run_en = 1;
    tick();
    chk("resume_run", 32'(state), 2);
    brk_en = 0; run_en = 0;
    tick();
    chk("halt_again", 32'(state), 1);

    // single step with STEP_REQ held for 5 cycles
    step_req = 1;
    ck_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_ck_en) ck_cnt++;
    end
    chk("step_once", 32'(ck_cnt), 1);
    chk("step_back_halt", 32'(state), 1);
    step_req = 0;
    tick();
    step_req = 1;
    tick();
    chk("step2_state", 32'(state), 3);
    tick();
    chk("step2_halt", 32'(state), 1);
    step_req = 0;

    // out-of-range write, also breakpoint target
    run_en = 1;
    tick();
    chk("oor_run", 32'(state), 2);
    brk_en = 1; brk_addr = 16;
    dmem_addr = 16; dmem_wdata = 32'hFFFF; dmem_read_wrn = 0; #1;
    chk("oor_rdata", dmem_rdata, 0);
    tick();
    dmem_read_wrn = 1; #1;
    chk("oor_brk", 32'(brk_hit), 1);
    chk("oor_state", 32'(state), 1);
    chk("oor_cnt", 32'(wr_count), 3);
    dmem_addr = 0; #1;
    chk("oor_no_alias", dmem_rdata, 0);

    // reset in the middle of RUN
    brk_en = 0; run_en = 0;
    tick();
    run_en = 1;
    tick();
    chk("run2_state", 32'(state), 2);
    dmem_addr = 0; dmem_wdata = 32'h1234; dmem_read_wrn = 0;
    tick();
    dmem_read_wrn = 1; #1;
    chk("mem0_1234", dmem_rdata, 32'h1234);
    step_req = 1;
    run_en = 0;
    rst = 1; #1;
    chk("arst_cken", 32'(cpu_ck_en), 0);
    chk("arst_rstn", 32'(cpu_rst_n), 0);
    chk("arst_state", 32'(state), 0);
    tick();
    rst = 0; #1;
    chk("arst_mem0", dmem_rdata, 0);
    chk("arst_cnt", 32'(wr_count), 0);
    chk("arst_brk", 32'(brk_hit), 0);
    repeat (7) tick();
    chk("rehold7", 32'(state), 0);
    tick();
    chk("rehold8", 32'(state), 1);
    tick();
    chk("held_step_no_fire", 32'(state), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
